// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for up to 8 hex digits on a
// common-anode seven-segment display.
// ScanTick is synchronized and edge-detected. Each rise steps to the next
// digit, and the new digit is preceded by one all-off cycle. The frame
// inputs are snapshotted when the scan wraps to digit 0.
// Optional feature: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank
// leading zero digits. Digit 0 is never blanked by this feature.
module seven_seg_scan #(
    parameter int NUM_DIGITS = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ScanTick,
    input  logic [31:0] Data,
    input  logic [7:0]  DigitEnable,
    input  logic [7:0]  DecimalPoint,
    input  logic        Blank,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        FrameStart
);

    localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

    logic        sync1, sync2, hist;
    logic        rise, wrap;
    logic [2:0]  idx, idx_next;
    logic [31:0] snap_data;
    logic [7:0]  snap_en, snap_dp;
    logic [3:0]  nib;
    logic [6:0]  seg_dec;
    logic        hide_lz, hide;
    logic [7:0]  an_dec;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= ScanTick;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Detect a tick rise and compute the next digit index with wraparound.
    always_comb begin
        rise     = sync2 & ~hist;
        wrap     = rise && (idx == LAST);
        idx_next = wrap ? 3'd0 : idx + 3'd1;
    end

    // Advance the digit index, and take a frame snapshot on wrap so that a frame never tears.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            idx       <= LAST;
            snap_data <= '0;
            snap_en   <= '0;
            snap_dp   <= '0;
        end else if (rise) begin
            idx <= idx_next;
            if (wrap) begin
                snap_data <= Data;
                snap_en   <= DigitEnable;
                snap_dp   <= DecimalPoint;
            end
        end
    end

    // Decode the current digit from the snapshot (active-low gfedcba).
    always_comb begin
        nib = snap_data[{idx, 2'b00} +: 4];
        case (nib)
            4'h0:    seg_dec = 7'b1000000;
            4'h1:    seg_dec = 7'b1111001;
            4'h2:    seg_dec = 7'b0100100;
            4'h3:    seg_dec = 7'b0110000;
            4'h4:    seg_dec = 7'b0011001;
            4'h5:    seg_dec = 7'b0010010;
            4'h6:    seg_dec = 7'b0000010;
            4'h7:    seg_dec = 7'b1111000;
            4'h8:    seg_dec = 7'b0000000;
            4'h9:    seg_dec = 7'b0010000;
            4'hA:    seg_dec = 7'b0001000;
            4'hB:    seg_dec = 7'b0000011;
            4'hC:    seg_dec = 7'b1000110;
            4'hD:    seg_dec = 7'b0100001;
            4'hE:    seg_dec = 7'b0000110;
            default: seg_dec = 7'b0001110;
        endcase
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] upper_zero;
    logic       zero_run;
    // upper_zero[i] is set when nibble i and every higher displayed nibble are zero.
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i < NUM_DIGITS) begin
                zero_run      = zero_run & (snap_data[i*4 +: 4] == 4'h0);
                upper_zero[i] = zero_run;
            end
        end
        hide_lz = (idx != 3'd0) && upper_zero[idx];
    end
`else
    // Leading zeros are shown like any other digit.
    always_comb hide_lz = 1'b0;
`endif

    // Anode gating: a disabled or blanked digit keeps its anode off; the segment and DP values are still driven.
    always_comb begin
        hide   = !snap_en[idx] || hide_lz;
        an_dec = hide ? 8'hFF : ~(8'h01 << idx);
    end

    // Registered outputs: all off on a digit change (ghosting gap) or while Blank is high.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            AN         <= 8'hFF;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
            FrameStart <= 1'b0;
        end else begin
            FrameStart <= wrap;
            if (rise || Blank) begin
                AN  <= 8'hFF;
                SEG <= 7'h7F;
                DP  <= 1'b1;
            end else begin
                AN  <= an_dec;
                SEG <= seg_dec;
                DP  <= ~snap_dp[idx];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan.
// It uses table-driven frame checks, hand-written corner sequences and randomized
// traffic. A per-cycle reference model, kept independent of the RTL, checks all of it.
module tb_seven_seg_scan;

    localparam int N = 8;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] SEGTAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [31:0] data = '0;
    logic [7:0]  en = '0;
    logic [7:0]  dpi = '0;
    logic        blank = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fs;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int fs_cnt  = 0;

    seven_seg_scan #(.NUM_DIGITS(N)) dut (
        .Clock(clk), .Reset(rst), .ScanTick(tick), .Data(data),
        .DigitEnable(en), .DecimalPoint(dpi), .Blank(blank),
        .AN(an), .SEG(seg), .DP(dp), .FrameStart(fs));

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: it tracks what the display should show, one cycle at a time.
    bit [2:0]    sh;           // last ScanTick samples, sh[0] newest
    int          m_idx;
    logic [31:0] m_data;
    logic [7:0]  m_en, m_dp;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;

    always @(posedge clk) begin
        bit rise_m, hide_m;
        if (rst) begin
            sh = '0; m_idx = N - 1; m_data = '0; m_en = '0; m_dp = '0;
            e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            rise_m = sh[1] && !sh[2];
            e_fs   = rise_m && (m_idx == N - 1);
            if (rise_m || blank) begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                hide_m = !m_en[m_idx] ||
                         (LZB && m_idx > 0 && (m_data >> (4 * m_idx)) == 0);
                e_an  = hide_m ? 8'hFF : ~(8'd1 << m_idx);
                e_seg = SEGTAB[(m_data >> (4 * m_idx)) & 32'hF];
                e_dp  = !m_dp[m_idx];
            end
            if (rise_m) begin
                m_idx = (m_idx + 1) % N;
                if (m_idx == 0) begin
                    m_data = data; m_en = en; m_dp = dpi;
                end
            end
            sh = {sh[1:0], tick};
        end
    end

    // Compare every cycle against the model, and count FrameStart pulses.
    always @(negedge clk) begin
        if (fs) fs_cnt++;
        if (chk_en) begin
            check("model_an",  32'(an),  32'(e_an));
            if (e_an != 8'hFF) check("model_seg", 32'(seg), 32'(e_seg));
            check("model_dp",  32'(dp),  32'(e_dp));
            check("model_fs",  32'(fs),  32'(e_fs));
        end
    end

    task automatic do_tick(input int hi, input int lo);
        tick = 1'b1;
        repeat (hi) @(negedge clk);
        tick = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [7:0]  en;
        logic [7:0]  dp;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    function automatic vec_t mk(logic [31:0] d, logic [7:0] e, logic [7:0] p,
                                logic [7:0] a, logic [6:0] s, logic o);
        vec_t v;
        v.data = d; v.en = e; v.dp = p; v.an = a; v.seg = s; v.dpo = o;
        return v;
    endfunction

    vec_t tab [32];
    logic [7:0] an_a  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] seg_a [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};

    initial begin
        int cnt;
        // Frame A: 0123ABCD. Frame B: data changes while digit 3 is active.
        // Frame C: partial enables and DP on digit 0. Frame D: leading zeros.
        for (int d = 0; d < 8; d++) begin
            tab[d]      = mk(32'h0123ABCD, 8'hFF, 8'h00, an_a[d], seg_a[d], 1'b1);
            tab[8 + d]  = mk(d < 4 ? 32'h0123ABCD : 32'hFFFFFFFF, 8'hFF, 8'h00,
                             an_a[d], seg_a[d], 1'b1);
            tab[16 + d] = mk(32'hFFFFFFFF, 8'h0F, 8'h01, d < 4 ? an_a[d] : 8'hFF,
                             7'h0E, d == 0 ? 1'b0 : 1'b1);
            tab[24 + d] = mk(32'h00000050, 8'hFF, 8'h00,
                             (LZB && d > 1) ? 8'hFF : an_a[d],
                             d == 1 ? 7'h12 : 7'h40, 1'b1);
        end

        repeat (3) @(negedge clk);
        check("reset_an",  32'(an),  32'hFF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp",  32'(dp),  32'h1);
        check("reset_fs",  32'(fs),  32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_an", 32'(an), 32'hFF);

        for (int i = 0; i < 32; i++) begin
            if (i % 8 == 0) fs_cnt = 0;
            data = tab[i].data; en = tab[i].en; dpi = tab[i].dp;
            do_tick(3, 5);
            check($sformatf("tab%0d_an", i), 32'(an), 32'(tab[i].an));
            if (tab[i].an != 8'hFF)
                check($sformatf("tab%0d_seg", i), 32'(seg), 32'(tab[i].seg));
            check($sformatf("tab%0d_dp", i), 32'(dp), 32'(tab[i].dpo));
            if (i % 8 == 7) check($sformatf("frame%0d_fs_count", i / 8), fs_cnt, 1);
        end

        // Blank held for 3 cycles while digit 2 is active.
        data = 32'h0123ABCD; en = 8'hFF; dpi = 8'h00;
        do_tick(3, 5); do_tick(3, 5); do_tick(3, 5);
        check("blank_pre_an", 32'(an), 32'hFB);
        blank = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) blank = 1'b0;
            check($sformatf("blank_an%0d", k), 32'(an), 32'hFF);
        end
        @(negedge clk);
        check("blank_resume_an",  32'(an),  32'hFB);
        check("blank_resume_seg", 32'(seg), 32'h03);

        // Reset lands on the same edge as a rise at digit 5.
        do_tick(3, 5); do_tick(3, 5); do_tick(3, 5);
        check("pre_rst_an", 32'(an), 32'hDF);
        tick = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b1; tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_rise_an", 32'(an), 32'hFF);
        check("rst_rise_fs", 32'(fs), 32'h0);
        repeat (3) @(negedge clk);
        fs_cnt = 0;
        do_tick(3, 5);
        check("post_rst_fs_count", fs_cnt, 1);
        check("post_rst_an",  32'(an),  32'hFE);
        check("post_rst_seg", 32'(seg), 32'h21);

        // Randomized traffic checked by the model.
        cnt = 2;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (cnt == 0) begin
                tick = ~tick;
                cnt  = $urandom_range(0, 5);
            end else cnt--;
            if ($urandom_range(0, 15) == 0) data = $urandom;
            if ($urandom_range(0, 31) == 0) data = $urandom & 32'h0000_0F0F;
            if ($urandom_range(0, 31) == 0) en = 8'($urandom);
            if ($urandom_range(0, 31) == 0) dpi = 8'($urandom);
            blank = ($urandom_range(0, 11) == 0);
            rst   = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0; blank = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
